program_loader: RTL

//  Writer side of the instruction path: encodes mnemonic+operand pairs into 8-bit IR words and writes them into program RAM.

---
 rtl/program_loader_pkg.sv | 46 ++++
 rtl/program_loader_instruction_encoder.sv | 36 +++
 rtl/program_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction path: mnemonic indices, opcodes,
// IR field positions and the loader FSM state encoding.
package program_loader_pkg;

    localparam int IR_W    = 8;
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int OPD_MSB = 3;
    localparam int OPD_LSB = 0;

    // Mnemonic indices as offered by the host on in_op
    localparam logic [3:0] MN_LOAD   = 4'd0;
    localparam logic [3:0] MN_ADD    = 4'd1;
    localparam logic [3:0] MN_SUB    = 4'd2;
    localparam logic [3:0] MN_AND    = 4'd3;
    localparam logic [3:0] MN_INPUT  = 4'd4;
    localparam logic [3:0] MN_OUTPUT = 4'd5;
    localparam logic [3:0] MN_JUMP   = 4'd6;
    localparam logic [3:0] MN_JUMPZ  = 4'd7;
    localparam logic [3:0] MN_JUMPNZ = 4'd8;
    localparam logic [3:0] MN_JUMPC  = 4'd9;
    localparam logic [3:0] MN_JUMPNC = 4'd10;

    // Opcodes as stored in IR[7:4]; the decode side uses these too
    localparam logic [3:0] OPC_LOAD   = 4'h0;
    localparam logic [3:0] OPC_ADD    = 4'h1;
    localparam logic [3:0] OPC_SUB    = 4'h2;
    localparam logic [3:0] OPC_AND    = 4'h3;
    localparam logic [3:0] OPC_INPUT  = 4'h4;
    localparam logic [3:0] OPC_OUTPUT = 4'h5;
    localparam logic [3:0] OPC_JUMP   = 4'h8;
    localparam logic [3:0] OPC_JUMPZ  = 4'h9;
    localparam logic [3:0] OPC_JUMPNZ = 4'hA;
    localparam logic [3:0] OPC_JUMPC  = 4'hB;
    localparam logic [3:0] OPC_JUMPNC = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_READ,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/program_loader_instruction_encoder.sv
// Combinational mnemonic+operand to IR word encoder; flags unknown mnemonics.
module instruction_encoder
    import program_loader_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [3:0]      operand,
    output logic [IR_W-1:0] ir,
    output logic            illegal
);

    logic [3:0] opcode;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        opcode  = OPC_LOAD;
        illegal = 1'b0;
        case (op)
            MN_LOAD:   opcode = OPC_LOAD;
            MN_ADD:    opcode = OPC_ADD;
            MN_SUB:    opcode = OPC_SUB;
            MN_AND:    opcode = OPC_AND;
            MN_INPUT:  opcode = OPC_INPUT;
            MN_OUTPUT: opcode = OPC_OUTPUT;
            MN_JUMP:   opcode = OPC_JUMP;
            MN_JUMPZ:  opcode = OPC_JUMPZ;
            MN_JUMPNZ: opcode = OPC_JUMPNZ;
            MN_JUMPC:  opcode = OPC_JUMPC;
            MN_JUMPNC: opcode = OPC_JUMPNC;
            default:   illegal = 1'b1;
        endcase
        ir                   = '0;
        ir[OPC_MSB:OPC_LSB]  = opcode;
        ir[OPD_MSB:OPD_LSB]  = operand;
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: encodes host words, writes them to program RAM, reads each
// back for verification, and holds the CPU in reset while loading.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              clock_enable,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_operand,
    input  logic              in_last,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [IR_W-1:0]   ram_wdata,
    output logic              ram_we,
    input  logic [IR_W-1:0]   ram_rdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written,
    output logic              err_illegal,
    output logic              err_verify,
    output logic              prog_full
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [IR_W-1:0]   enc_q;
    logic              last_q;
    logic [IR_W-1:0]   enc_ir;
    logic              enc_illegal;
    logic              accept;

    instruction_encoder u_encoder (
        .op      (in_op),
        .operand (in_operand),
        .ir      (enc_ir),
        .illegal (enc_illegal)
    );

    assign accept = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous to clock.
    always_ff @(posedge clock) begin
        if (clear)
            state <= ST_IDLE;
        else if (clock_enable)
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (start) state_n = ST_LOAD;
            ST_LOAD: begin
                if (accept) begin
                    if (!enc_illegal)
                        state_n = ST_WRITE;
                    else if (in_last)
                        state_n = ST_DONE;
                end
            end
            ST_WRITE: state_n = ST_READ;
            ST_READ:  state_n = ST_CHECK;
            ST_CHECK: state_n = (addr == ADDR_MAX || last_q) ? ST_DONE : ST_LOAD;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        cpu_hold  = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
            end
            ST_WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = addr;
                ram_wdata = enc_q;
                cpu_hold  = 1'b1;
            end
            ST_READ: begin
                ram_addr = addr;
                cpu_hold = 1'b1;
            end
            ST_CHECK: cpu_hold = 1'b1;
            ST_DONE:  done     = 1'b1;
            default: ;
        endcase
    end

    // Address, latched word, counter and sticky flags
    always_ff @(posedge clock) begin
        if (clear) begin
            addr          <= '0;
            enc_q         <= '0;
            last_q        <= 1'b0;
            words_written <= '0;
            err_illegal   <= 1'b0;
            err_verify    <= 1'b0;
            prog_full     <= 1'b0;
        end else if (clock_enable) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr          <= '0;
                        words_written <= '0;
                        err_illegal   <= 1'b0;
                        err_verify    <= 1'b0;
                        prog_full     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (enc_illegal) begin
                            err_illegal <= 1'b1;
                        end else begin
                            enc_q  <= enc_ir;
                            last_q <= in_last;
                        end
                    end
                end
                ST_CHECK: begin
                    // Readback for the READ-cycle address arrives here
                    if (ram_rdata != enc_q)
                        err_verify <= 1'b1;
                    words_written <= words_written + CNT_ONE;
                    if (addr == ADDR_MAX)
                        prog_full <= 1'b1;
                    else
                        addr <= addr + ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule
